// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling with start-bit
// glitch rejection, one-deep holding register with framing/overrun pulses.
module uart_rx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_i,
   input  logic       rd_i,
   output logic [7:0] d_o,
   output logic       v_o,
   output logic       frame_err_o,
   output logic       ovr_o,
   output logic       busy_o
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int TW   = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
   localparam logic [TW-1:0] T_BIT  = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          rx_meta;
   logic          rx_s;

   // Flops reset high so a reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         timer       <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         d_o         <= '0;
         v_o         <= 1'b0;
         frame_err_o <= 1'b0;
         ovr_o       <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         frame_err_o <= 1'b0;
         ovr_o       <= 1'b0;
         if (rd_i && v_o)
            v_o <= 1'b0;

         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state  <= START;
                  timer  <= T_HALF;
                  busy_o <= 1'b1;
               end
            end

            START: begin
               if (timer != '0)
                  timer <= timer - 1'b1;
               else if (!rx_s) begin
                  state   <= DATA;
                  timer   <= T_BIT;
                  bit_idx <= '0;
               end else begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            end

            DATA: begin
               if (timer != '0)
                  timer <= timer - 1'b1;
               else begin
                  shift[bit_idx] <= rx_s;
                  bit_idx        <= bit_idx + 3'd1;
                  timer          <= T_BIT;
                  if (bit_idx == 3'd7)
                     state <= STOP;
               end
            end

            // Leaving at mid-stop leaves half a bit to catch a back-to-back start.
            STOP: begin
               if (timer != '0)
                  timer <= timer - 1'b1;
               else if (rx_s) begin
                  d_o    <= shift;
                  v_o    <= 1'b1;
                  ovr_o  <= v_o && !rd_i;
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else begin
                  frame_err_o <= 1'b1;
                  state       <= WAIT_IDLE;
               end
            end

            WAIT_IDLE: begin
               if (rx_s) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            end

            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 4 clocks/bit: vector table of frames plus
// hand sequences for glitch, framing error and mid-frame reset.
module tb_uart_rx;

   localparam int CPB  = 4;
   localparam int LOGN = 4096;

   logic       clk;
   logic       reset;
   logic       rx_i;
   logic       rd_i;
   logic [7:0] d_o;
   logic       v_o;
   logic       frame_err_o;
   logic       ovr_o;
   logic       busy_o;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .reset(reset), .rx_i(rx_i), .rd_i(rd_i),
      .d_o(d_o), .v_o(v_o), .frame_err_o(frame_err_o),
      .ovr_o(ovr_o), .busy_o(busy_o)
   );

   typedef struct {
      logic [7:0] data;
      logic       rd_done;
      logic       rd_after;
      logic [7:0] exp_d;
      logic       exp_v;
      logic       exp_fe;
      logic       exp_ovr;
   } vec_t;

   vec_t vecs[9];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   fe_cnt = 0;
   int   ovr_cnt = 0;
   logic busy_log[LOGN];
   logic fe_log[LOGN];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cyc is the index of the most recent rising edge.
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (cyc < LOGN) begin
         busy_log[cyc] = busy_o;
         fe_log[cyc]   = frame_err_o;
      end
      if (frame_err_o === 1'b1) fe_cnt++;
      if (ovr_o === 1'b1) ovr_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called at a falling edge; returns at the falling edge before the stop sample.
   task automatic send(input logic [7:0] b, input logic stopb, output int t0);
      t0 = cyc;
      rx_i = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx_i = stopb;
      repeat (CPB) @(negedge clk);
   endtask

   initial begin
      int         t0;
      int         e0;
      int         l0;
      logic [7:0] c3;

      vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h11, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h22, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{8'h11, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{8'hAA, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0};

      reset = 1'b1;
      rx_i  = 1'b1;
      rd_i  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_d", d_o, 0);
      chk("rst_v", v_o, 0);
      chk("rst_fe", frame_err_o, 0);
      chk("rst_ovr", ovr_o, 0);
      chk("rst_busy", busy_o, 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      foreach (vecs[n]) begin
         send(vecs[n].data, 1'b1, t0);
         e0 = t0 + 1;
         chk($sformatf("v%0d_ovr_early", n), ovr_o, 0);
         rd_i = vecs[n].rd_done;
         @(negedge clk);
         rd_i = 1'b0;
         chk($sformatf("v%0d_d", n), d_o, vecs[n].exp_d);
         chk($sformatf("v%0d_v", n), v_o, vecs[n].exp_v);
         chk($sformatf("v%0d_fe", n), frame_err_o, vecs[n].exp_fe);
         chk($sformatf("v%0d_ovr", n), ovr_o, vecs[n].exp_ovr);
         chk($sformatf("v%0d_busy_end", n), busy_o, 0);
         chk($sformatf("v%0d_busy_e3", n), busy_log[e0+3], 1);
         chk($sformatf("v%0d_busy_e39", n), busy_log[e0+39], 1);
         if (vecs[n].rd_after) begin
            rd_i = 1'b1;
            @(negedge clk);
            rd_i = 1'b0;
            chk($sformatf("v%0d_v_clr", n), v_o, 0);
            chk($sformatf("v%0d_ovr_1cyc", n), ovr_o, 0);
         end
      end

      // Glitch: one clock low is rejected at mid start bit.
      repeat (4) @(negedge clk);
      t0 = cyc;
      rx_i = 1'b0;
      @(negedge clk);
      rx_i = 1'b1;
      e0 = t0 + 1;
      repeat (5) @(negedge clk);
      chk("glitch_busy_e3", busy_log[e0+3], 1);
      chk("glitch_busy_e5", busy_o, 0);
      chk("glitch_v", v_o, 0);
      repeat (4) @(negedge clk);
      send(8'h3C, 1'b1, t0);
      @(negedge clk);
      chk("after_glitch_d", d_o, 8'h3C);
      chk("after_glitch_v", v_o, 1);
      rd_i = 1'b1;
      @(negedge clk);
      rd_i = 1'b0;

      // Framing error: stop bit low, line held low, then released.
      send(8'h81, 1'b0, t0);
      e0 = t0 + 1;
      repeat (16) @(negedge clk);
      rx_i = 1'b1;
      l0 = cyc;
      repeat (4) @(negedge clk);
      chk("fe_pre", fe_log[e0+39], 0);
      chk("fe_pulse", fe_log[e0+40], 1);
      chk("fe_post", fe_log[e0+41], 0);
      chk("fe_busy_stuck", busy_log[e0+50], 1);
      chk("fe_busy_l2", busy_log[l0+2], 1);
      chk("fe_busy_l3", busy_log[l0+3], 0);
      chk("fe_v", v_o, 0);
      chk("fe_d_kept", d_o, 8'h3C);

      // Reset in the middle of data bit 4 with an unread byte pending.
      repeat (3) @(negedge clk);
      send(8'h77, 1'b1, t0);
      @(negedge clk);
      chk("pre_rst_d", d_o, 8'h77);
      chk("pre_rst_v", v_o, 1);
      c3 = 8'hC3;
      rx_i = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx_i = c3[i];
         repeat (CPB) @(negedge clk);
      end
      rx_i = c3[4];
      repeat (2) @(negedge clk);
      chk("mid_busy", busy_o, 1);
      reset = 1'b1;
      rx_i  = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mrst_d", d_o, 0);
      chk("mrst_v", v_o, 0);
      chk("mrst_busy", busy_o, 0);
      chk("mrst_fe", frame_err_o, 0);
      chk("mrst_ovr", ovr_o, 0);
      repeat (8) @(negedge clk);
      chk("mrst_idle_v", v_o, 0);
      chk("mrst_idle_busy", busy_o, 0);
      send(8'h5A, 1'b1, t0);
      @(negedge clk);
      chk("after_rst_d", d_o, 8'h5A);
      chk("after_rst_v", v_o, 1);
      repeat (4) @(negedge clk);

      chk("total_ovr_pulses", ovr_cnt, 1);
      chk("total_fe_pulses", fe_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
